// File: rtl/cam_match_encoder.sv
// rtl/cam_match_encoder.sv - CAM match vector priority encoder with 2-stage handshake pipeline and hit/miss stats
module cam_match_encoder #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DEPTH-1:0] match,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hit,
    output logic             out_multi,
    output logic [IDX_W-1:0] out_index,
    output logic [IDX_W:0]   out_count,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    logic [DEPTH-1:0] r_s1;
    logic             r_s1_valid;
    logic             r_out_valid;
    logic             r_out_hit;
    logic             r_out_multi;
    logic [IDX_W-1:0] r_out_index;
    logic [IDX_W:0]   r_out_count;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_s1_adv;
    logic             w_out_fire;
    logic [IDX_W-1:0] w_index;
    logic [IDX_W:0]   w_count;

    // Ready depends only on pipeline occupancy, never on in_valid
    always_comb begin
        w_in_ready = !r_s1_valid || !r_out_valid || out_ready;
        w_accept   = in_valid && w_in_ready;
        w_s1_adv   = r_s1_valid && (!r_out_valid || out_ready);
        w_out_fire = r_out_valid && out_ready;
    end

    // Lowest-index priority encode and popcount of the captured vector
    always_comb begin
        w_index = '0;
        w_count = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_s1[i]) begin
                w_index = IDX_W'(i);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_count = w_count + {{IDX_W{1'b0}}, r_s1[i]};
        end
    end

    // Stage 1: capture the match vector on an accepted input
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1       <= '0;
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1       <= match;
            r_s1_valid <= 1'b1;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: load encoded result, hold it stable while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_hit   <= 1'b0;
            r_out_multi <= 1'b0;
            r_out_index <= '0;
            r_out_count <= '0;
        end else if (w_s1_adv) begin
            r_out_valid <= 1'b1;
            r_out_hit   <= |r_s1;
            r_out_multi <= (w_count >= (IDX_W + 1)'(2));
            r_out_index <= w_index;
            r_out_count <= w_count;
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

    // Saturating statistics on delivered results; clear has priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (clr_stats) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_out_fire) begin
            if (r_out_hit) begin
                if (r_hit_cnt != {CNT_W{1'b1}}) begin
                    r_hit_cnt <= r_hit_cnt + 1'b1;
                end
            end else begin
                if (r_miss_cnt != {CNT_W{1'b1}}) begin
                    r_miss_cnt <= r_miss_cnt + 1'b1;
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_hit   = r_out_hit;
    assign out_multi = r_out_multi;
    assign out_index = r_out_index;
    assign out_count = r_out_count;
    assign hit_cnt   = r_hit_cnt;
    assign miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_cam_match_encoder.sv
// tb/tb_cam_match_encoder.sv - directed self-checking bench for cam_match_encoder
module tb_cam_match_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] match;
    logic        out_valid;
    logic        out_ready;
    logic        out_hit;
    logic        out_multi;
    logic [3:0]  out_index;
    logic [4:0]  out_count;
    logic        clr_stats;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    logic        s_in_ready;
    logic        s_out_valid;
    logic        s_out_hit;
    logic        s_out_multi;
    logic [3:0]  s_out_index;
    logic [4:0]  s_out_count;
    logic [1:0]  s_hit_cnt;
    logic [1:0]  s_miss_cnt;

    int checks;
    int failures;
    int exp_hit;
    int exp_miss;

    cam_match_encoder #(.DEPTH(16), .IDX_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .match(match), .out_valid(out_valid), .out_ready(out_ready),
        .out_hit(out_hit), .out_multi(out_multi), .out_index(out_index),
        .out_count(out_count), .clr_stats(clr_stats),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    cam_match_encoder #(.DEPTH(16), .IDX_W(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .match(match), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_hit(s_out_hit), .out_multi(s_out_multi), .out_index(s_out_index),
        .out_count(s_out_count), .clr_stats(clr_stats),
        .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        exp_hit  = 0;
        exp_miss = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; match = '0; out_ready = 1'b0; clr_stats = 1'b0;
        #3;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_index !== 4'd0 || out_count !== 5'd0 || out_hit !== 1'b0 || out_multi !== 1'b0) begin
            failures++; $display("FAIL reset_outputs got idx=%0d cnt=%0d hit=%b multi=%b want 0/0/0/0", out_index, out_count, out_hit, out_multi); end
        checks++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
            failures++; $display("FAIL reset_counters got hit=%0d miss=%0d want 0/0", hit_cnt, miss_cnt); end
        step(); step();
        rst = 1'b1;
        step();
        exp_hit = 0; exp_miss = 0;
    endtask

    task automatic test_encode();
        logic [15:0] vec   [4] = '{16'h0004, 16'h8009, 16'hFFFF, 16'h0000};
        logic [3:0]  e_idx [4] = '{4'd2, 4'd0, 4'd0, 4'd0};
        logic [4:0]  e_cnt [4] = '{5'd1, 5'd3, 5'd16, 5'd0};
        logic        e_hit [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic        e_mul [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; match = vec[k];
            step();
            in_valid = 1'b0; match = 16'hDEAD;
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL enc%0d_latency out_valid got %b want 0", k, out_valid); end
            step();
            checks++; if (out_valid !== 1'b1 || out_index !== e_idx[k] || out_count !== e_cnt[k] || out_hit !== e_hit[k] || out_multi !== e_mul[k]) begin
                failures++; $display("FAIL enc%0d_result got v=%b idx=%0d cnt=%0d hit=%b multi=%b want v=1 idx=%0d cnt=%0d hit=%b multi=%b",
                    k, out_valid, out_index, out_count, out_hit, out_multi, e_idx[k], e_cnt[k], e_hit[k], e_mul[k]); end
            if (e_hit[k]) exp_hit++; else exp_miss++;
            step();
            checks++; if (hit_cnt !== 16'(exp_hit) || miss_cnt !== 16'(exp_miss) || out_valid !== 1'b0) begin
                failures++; $display("FAIL enc%0d_stats got hit=%0d miss=%0d v=%b want hit=%0d miss=%0d v=0", k, hit_cnt, miss_cnt, out_valid, exp_hit, exp_miss); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vec   [4] = '{16'h0002, 16'h0020, 16'h0200, 16'h2000};
        logic [3:0]  e_idx [4] = '{4'd1, 4'd5, 4'd9, 4'd13};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin in_valid = 1'b1; match = vec[i]; end
            else begin in_valid = 1'b0; match = '0; end
            step();
            if (i > 0) begin
                checks++; if (out_valid !== 1'b1 || out_index !== e_idx[i-1]) begin
                    failures++; $display("FAIL b2b_%0d got v=%b idx=%0d want v=1 idx=%0d", i-1, out_valid, out_index, e_idx[i-1]); end
            end
        end
        in_valid = 1'b0;
        exp_hit += 4;
        step();
        checks++; if (hit_cnt !== 16'(exp_hit) || out_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_stats got hit=%0d v=%b want hit=%0d v=0", hit_cnt, out_valid, exp_hit); end
    endtask

    task automatic test_backpressure();
        logic [3:0] e_idx [3] = '{4'd0, 4'd4, 4'd8};
        out_ready = 1'b0;
        in_valid = 1'b1; match = 16'h0001;
        step();
        match = 16'h0010;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after1 got %b want 1", in_ready); end
        step();
        match = 16'h0100;
        for (int c = 0; c < 4; c++) begin
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_index !== 4'd0) begin
                failures++; $display("FAIL bp_stall%0d got rdy=%b v=%b idx=%0d want rdy=0 v=1 idx=0", c, in_ready, out_valid, out_index); end
            if (c < 3) step();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_release got %b want 1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                checks++; if (out_valid !== 1'b1 || out_index !== e_idx[i]) begin
                    failures++; $display("FAIL bp_order%0d got v=%b idx=%0d want v=1 idx=%0d", i, out_valid, out_index, e_idx[i]); end
            end
            step();
            in_valid = 1'b0;
        end
        exp_hit += 3;
        checks++; if (out_valid !== 1'b0 || hit_cnt !== 16'(exp_hit)) begin
            failures++; $display("FAIL bp_drain got v=%b hit=%0d want v=0 hit=%0d", out_valid, hit_cnt, exp_hit); end
    endtask

    task automatic test_saturation();
        clear_stats();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            match = (i == 5) ? 16'h0000 : 16'h0001;
            step();
        end
        in_valid = 1'b0;
        step(); step();
        checks++; if (s_hit_cnt !== 2'd3 || s_miss_cnt !== 2'd1) begin
            failures++; $display("FAIL sat_counts got hit=%0d miss=%0d want 3/1", s_hit_cnt, s_miss_cnt); end
        checks++; if (hit_cnt !== 16'd5 || miss_cnt !== 16'd1) begin
            failures++; $display("FAIL wide_counts got hit=%0d miss=%0d want 5/1", hit_cnt, miss_cnt); end
        in_valid = 1'b1; match = 16'h0040;
        step();
        in_valid = 1'b0;
        step();
        clr_stats = 1'b1;
        checks++; if (out_valid !== 1'b1 || out_hit !== 1'b1) begin
            failures++; $display("FAIL clr_setup got v=%b hit=%b want 1/1", out_valid, out_hit); end
        step();
        clr_stats = 1'b0;
        checks++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0 || s_hit_cnt !== 2'd0 || s_miss_cnt !== 2'd0) begin
            failures++; $display("FAIL clr_wins got hit=%0d miss=%0d shit=%0d smiss=%0d want 0", hit_cnt, miss_cnt, s_hit_cnt, s_miss_cnt); end
        exp_hit = 0; exp_miss = 0;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        in_valid = 1'b1; match = 16'h0080;
        step();
        in_valid = 1'b0;
        step(); step();
        checks++; if (hit_cnt !== 16'd1) begin failures++; $display("FAIL rst_pre_count got %0d want 1", hit_cnt); end
        out_ready = 1'b0;
        in_valid = 1'b1; match = 16'h0800;
        step();
        match = 16'h1000;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++; $display("FAIL rst_full got v=%b rdy=%b want 1/0", out_valid, in_ready); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
            failures++; $display("FAIL rst_async got v=%b rdy=%b hit=%0d miss=%0d want 0/1/0/0", out_valid, in_ready, hit_cnt, miss_cnt); end
        step();
        rst = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (out_valid !== 1'b0 || hit_cnt !== 16'd0) begin
                failures++; $display("FAIL rst_no_stale%0d got v=%b hit=%0d want 0/0", c, out_valid, hit_cnt); end
        end
    endtask

    initial begin
        checks = 0; failures = 0; exp_hit = 0; exp_miss = 0;
        test_reset();
        test_encode();
        test_back_to_back();
        test_backpressure();
        test_saturation();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
